// File: rtl/switch_pkg.sv
// Shared types and constants for the four-port byte switch.
package switch_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned PORT_W    = $clog2(NUM_PORTS);

  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [PORT_W-1:0] port_idx_t;

  // Input framing FSM: waiting for a DA, forwarding a packet, or discarding one.
  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StDrop
  } state_e;

endpackage

// File: rtl/switch_fifo.sv
// Single-clock byte FIFO with occupancy count; one instance per output port.
module switch_fifo
  import switch_pkg::*;
#(
  parameter int unsigned Depth = 64,
  localparam int unsigned PtrW = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  byte_t         wdata_i,
  output byte_t         rdata_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [PtrW:0] count_o
);

  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(Depth);

  byte_t           mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  // Pop is qualified by non-empty; a push into a full FIFO still lands when a pop frees a slot.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FullCount) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FullCount);
  assign count_o = count_q;

endmodule

// File: rtl/switch.sv
// Four-port packet switch: DA decode against programmable port addresses,
// per-port FIFO buffering and registered read-side outputs.
module switch
  import switch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              mem_rd_wr,
  input  logic [1:0]        mem_add,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] data,
  input  logic              data_status,
  input  logic              read_0,
  input  logic              read_1,
  input  logic              read_2,
  input  logic              read_3,
  output logic [DATA_W-1:0] port0,
  output logic [DATA_W-1:0] port1,
  output logic [DATA_W-1:0] port2,
  output logic [DATA_W-1:0] port3,
  output logic              ready_0,
  output logic              ready_1,
  output logic              ready_2,
  output logic              ready_3,
  output logic              fifo_full
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  byte_t                addr_reg_q [NUM_PORTS];
  byte_t                addr_reg_d [NUM_PORTS];
  byte_t                port_q     [NUM_PORTS];
  byte_t                port_d     [NUM_PORTS];
  byte_t                rdata      [NUM_PORTS];
  logic [CntW-1:0]      count      [NUM_PORTS];
  state_e               state_q, state_d;
  port_idx_t            dest_q, dest_d;
  port_idx_t            da_idx;
  logic                 da_hit;
  logic [NUM_PORTS-1:0] read, push, empty, full, ready;

  assign read = {read_3, read_2, read_1, read_0};

  // Port-address register writes; reads are a no-op.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) addr_reg_d[i] = addr_reg_q[i];
    if (mem_en && mem_rd_wr) addr_reg_d[mem_add] = mem_data;
  end

  // DA match: scan high to low so the lowest matching index wins.
  always_comb begin
    da_hit = 1'b0;
    da_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (data == addr_reg_q[i]) begin
        da_hit = 1'b1;
        da_idx = port_idx_t'(i);
      end
    end
  end

  // Framing FSM next state and FIFO push steering.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    push    = '0;
    unique case (state_q)
      StIdle: begin
        if (data_status) begin
          if (da_hit) begin
            dest_d       = da_idx;
            push[da_idx] = 1'b1;
            state_d      = StFwd;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StFwd: begin
        if (data_status) push[dest_q] = 1'b1;
        else             state_d      = StIdle;
      end
      StDrop: begin
        if (!data_status) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output byte registers capture the FIFO head only on a real pop.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_d[i] = (read[i] && !empty[i]) ? rdata[i] : port_q[i];
    end
  end

  // Control state, address registers and output bytes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      dest_q  <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        addr_reg_q[i] <= '0;
        port_q[i]     <= '0;
      end
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        addr_reg_q[i] <= addr_reg_d[i];
        port_q[i]     <= port_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_fifo
    switch_fifo #(
      .Depth (FIFO_DEPTH)
    ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (push[g]),
      .pop_i   (read[g]),
      .wdata_i (data),
      .rdata_o (rdata[g]),
      .empty_o (empty[g]),
      .full_o  (full[g]),
      .count_o (count[g])
    );
    assign ready[g] = (count[g] != '0);
  end

  assign port0     = port_q[0];
  assign port1     = port_q[1];
  assign port2     = port_q[2];
  assign port3     = port_q[3];
  assign ready_0   = ready[0];
  assign ready_1   = ready[1];
  assign ready_2   = ready[2];
  assign ready_3   = ready[3];
  assign fifo_full = |full;

endmodule

// File: tb/tb_switch.sv
// Scoreboard bench for the four-port switch: stimulus queues expected bytes per
// port, a negedge monitor checks every byte that a pop presents.
module tb_switch;
  import switch_pkg::*;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_en, mem_rd_wr;
  logic [1:0] mem_add;
  byte_t      mem_data, data;
  logic       data_status;
  logic [3:0] rd;
  byte_t      port_w [4];
  wire  [3:0] ready_v;
  wire        fifo_full;

  int    n_checks = 0;
  int    n_fail   = 0;
  byte_t exp_q [4][$];
  logic  pend  [4];
  byte_t mon_exp;

  always #5 clk = ~clk;

  switch #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_en      (mem_en),
    .mem_rd_wr   (mem_rd_wr),
    .mem_add     (mem_add),
    .mem_data    (mem_data),
    .data        (data),
    .data_status (data_status),
    .read_0      (rd[0]),
    .read_1      (rd[1]),
    .read_2      (rd[2]),
    .read_3      (rd[3]),
    .port0       (port_w[0]),
    .port1       (port_w[1]),
    .port2       (port_w[2]),
    .port3       (port_w[3]),
    .ready_0     (ready_v[0]),
    .ready_1     (ready_v[1]),
    .ready_2     (ready_v[2]),
    .ready_3     (ready_v[3]),
    .fifo_full   (fifo_full)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input byte_t d);
    mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = a; mem_data = d;
    tick();
    mem_en = 1'b0; mem_rd_wr = 1'b0;
  endtask

  task automatic send_raw(input byte_t b);
    data_status = 1'b1; data = b;
    tick();
  endtask

  task automatic send_fwd(input int p, input byte_t b);
    exp_q[p].push_back(b);
    send_raw(b);
  endtask

  task automatic gap();
    data_status = 1'b0;
    tick();
  endtask

  task automatic read_n(input int p, input int n);
    rd[p] = 1'b1;
    repeat (n) tick();
    rd[p] = 1'b0;
    tick();
  endtask

  // Monitor: a pop seen before an edge must show the next expected byte at the following negedge.
  initial for (int i = 0; i < 4; i++) pend[i] = 1'b0;
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pend[i] && reset) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("port%0d_unexpected_pop", i), 32'd1, 32'd0);
        end else begin
          mon_exp = exp_q[i].pop_front();
          check($sformatf("port%0d_data", i), 32'(port_w[i]), 32'(mon_exp));
        end
      end
      pend[i] <= rd[i] && ready_v[i] && reset;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; mem_en = 1'b0; mem_rd_wr = 1'b0; mem_add = '0; mem_data = '0;
    data = '0; data_status = 1'b0; rd = '0;
    #12;
    check("reset_ready", 32'(ready_v), 32'h0);
    check("reset_full", 32'(fifo_full), 32'h0);
    check("reset_port1", 32'(port_w[1]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();

    // Configure and forward
    cfg_write(2'd0, 8'h11);
    cfg_write(2'd1, 8'h22);
    cfg_write(2'd2, 8'h33);
    cfg_write(2'd3, 8'h44);
    check("t1_ready_pre", 32'(ready_v), 32'h0);
    send_fwd(1, 8'h22);
    check("t1_ready_after_da", 32'(ready_v), 32'h2);
    send_fwd(1, 8'h05);
    send_fwd(1, 8'h02);
    send_fwd(1, 8'hAA);
    send_fwd(1, 8'hBB);
    send_fwd(1, 8'h7D);
    gap();
    read_n(1, 6);
    check("t1_ready_after_drain", 32'(ready_v), 32'h0);
    check("t1_queue_empty", 32'(exp_q[1].size()), 32'd0);

    // Unmatched DA, then a packet to port 3 after a one-cycle gap
    send_raw(8'h99);
    send_raw(8'h01);
    send_raw(8'h02);
    gap();
    check("t2_drop_ready", 32'(ready_v), 32'h0);
    send_fwd(3, 8'h44);
    send_fwd(3, 8'h01);
    send_fwd(3, 8'h02);
    gap();
    check("t2_port3_only", 32'(ready_v), 32'h8);
    read_n(3, 3);
    check("t2_ready_after_drain", 32'(ready_v), 32'h0);

    // Overflow: DEPTH+4 bytes, only the first DEPTH kept
    send_fwd(0, 8'h11);
    for (int i = 1; i <= DEPTH - 2; i++) send_fwd(0, byte_t'(i));
    check("t3_not_full_yet", 32'(fifo_full), 32'h0);
    send_fwd(0, byte_t'(DEPTH - 1));
    check("t3_full", 32'(fifo_full), 32'h1);
    for (int i = DEPTH; i <= DEPTH + 3; i++) send_raw(byte_t'(i));
    gap();
    check("t3_still_full", 32'(fifo_full), 32'h1);
    rd[0] = 1'b1;
    tick();
    check("t3_full_clears", 32'(fifo_full), 32'h0);
    repeat (DEPTH + 1) tick();
    rd[0] = 1'b0;
    tick();
    check("t3_ready_after_drain", 32'(ready_v), 32'h0);
    check("t3_port0_holds", 32'(port_w[0]), 32'(DEPTH - 1));
    check("t3_queue_empty", 32'(exp_q[0].size()), 32'd0);

    // Streaming with read_2 held high: occupancy stays at one
    rd[2] = 1'b1;
    send_fwd(2, 8'h33);
    check("t4_ready_da", 32'(ready_v), 32'h4);
    for (int i = 0; i < 5; i++) begin
      send_fwd(2, byte_t'(8'hA0 + i));
      check("t4_ready_stream", 32'(ready_v), 32'h4);
    end
    gap();
    check("t4_count_le_1", 32'(ready_v), 32'h0);
    rd[2] = 1'b0;
    tick();
    check("t4_queue_empty", 32'(exp_q[2].size()), 32'd0);

    // Asynchronous reset in the middle of a packet
    send_raw(8'h11);
    send_raw(8'h01);
    check("t5_ready_pre_reset", 32'(ready_v), 32'h1);
    #2;
    reset = 1'b0;
    data_status = 1'b0;
    #1;
    check("t5_async_ready", 32'(ready_v), 32'h0);
    check("t5_async_port0", 32'(port_w[0]), 32'h0);
    check("t5_async_full", 32'(fifo_full), 32'h0);
    for (int p = 0; p < 4; p++) exp_q[p].delete();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    send_fwd(0, 8'h00);
    send_fwd(0, 8'h5A);
    gap();
    check("t5_da00_port0", 32'(ready_v), 32'h1);
    read_n(0, 2);
    check("t5_ready_after_drain", 32'(ready_v), 32'h0);

    // Reconfigure reg 1 while its packet is in flight
    cfg_write(2'd1, 8'h22);
    send_fwd(1, 8'h22);
    send_fwd(1, 8'h10);
    mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = 2'd1; mem_data = 8'h55;
    send_fwd(1, 8'h11);
    mem_en = 1'b0; mem_rd_wr = 1'b0;
    send_fwd(1, 8'h12);
    gap();
    send_raw(8'h22);
    send_raw(8'h99);
    gap();
    check("t6_old_addr_dropped", 32'(ready_v), 32'h2);
    read_n(1, 4);
    check("t6_ready_after_drain", 32'(ready_v), 32'h0);
    // Read-mode access must not overwrite the register
    mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = 2'd1; mem_data = 8'h77;
    tick();
    mem_en = 1'b0;
    send_fwd(1, 8'h55);
    gap();
    check("t6_new_addr_routes", 32'(ready_v), 32'h2);
    read_n(1, 1);

    for (int p = 0; p < 4; p++) check($sformatf("leftover_port%0d", p), 32'(exp_q[p].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
